// File: rtl/seg_display_scanner.sv
// Scans a snapshotted 4*NUM_DIGITS-bit value across a multiplexed common-anode
// seven-segment display, one digit per refresh slot, with guard-band blanking.
module seg_display_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 64,
    localparam int DIGIT_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int DIV_W       = $clog2(REFRESH_DIV)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [4*NUM_DIGITS-1:0]   value_i,
    input  logic                      load_i,
    input  logic                      blank_lz_i,
    input  logic [NUM_DIGITS-1:0]     dp_mask_i,
    output logic [3:0]                nibble_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      dp_o,
    output logic [DIGIT_W-1:0]        digit_idx_o,
    output logic                      frame_done_o
);

    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [DIGIT_W-1:0]      digit_idx_q, digit_idx_d;
    logic                    frame_done_q, frame_done_d;
    logic                    blank_q;

    logic                    last_cnt;
    logic                    last_digit;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    hi_zero;
    logic                    guard;
    logic                    blanked;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_q       <= '0;
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            frame_done_q <= 1'b0;
            blank_q      <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            frame_done_q <= frame_done_d;
            blank_q      <= blank_lz_i;
        end
    end

    always_comb begin
        snap_d       = load_i ? value_i : snap_q;
        last_cnt     = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
        last_digit   = (digit_idx_q == DIGIT_W'(NUM_DIGITS - 1));
        div_cnt_d    = last_cnt ? '0 : div_cnt_q + DIV_W'(1);
        digit_idx_d  = digit_idx_q;
        if (last_cnt) begin
            digit_idx_d = last_digit ? '0 : digit_idx_q + DIGIT_W'(1);
        end
        frame_done_d = last_cnt && last_digit;
    end

    // zero_from[d] is set when every nibble from d up to the top digit is zero.
    always_comb begin
        zero_from = '0;
        hi_zero   = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            hi_zero      = hi_zero & (snap_q[4*d +: 4] == 4'h0);
            zero_from[d] = hi_zero;
        end
    end

    always_comb begin
        guard    = (div_cnt_q < DIV_W'(GUARD_CYCLES));
        blanked  = blank_q && (digit_idx_q != '0) && zero_from[digit_idx_q];
        nibble_o = snap_q[4*digit_idx_q +: 4];
        an_o     = '1;
        dp_o     = 1'b1;
        if (!guard && !blanked) begin
            an_o[digit_idx_q] = 1'b0;
            dp_o              = ~dp_mask_i[digit_idx_q];
        end
    end

    assign digit_idx_o  = digit_idx_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display. It snapshots a 4·N-bit debug value, such as the PC or predictor hit/miss counters, from the core on a load strobe. It scans the snapshot one digit at a time and presents the selected hex nibble to the downstream hex-to-segment decoder, along with the digit's anode enable and decimal point. It sits directly upstream of the segment decoder, and its nibble output drives the decoder's 4-bit input.

Parameters:
NUM_DIGITS, 8, number of display digits; legal range 2..8.
REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 2.
GUARD_CYCLES, 64, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
value  in  4*NUM_DIGITS  value to display; digit 0 = bits [3:0] (rightmost).
load  in  1  capture value into snapshot this cycle.
blank_lz  in  1  enable leading-zero blanking.
dp_mask  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
nibble  out  4  hex digit for the segment decoder.
an  out  NUM_DIGITS  anode enables, active-low; one-hot-low or all ones.
dp  out  1  decimal point, active-low.
digit_idx  out  clog2(NUM_DIGITS)  digit currently scanned.
frame_done  out  1  one-cycle pulse at end of full scan.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Register reset values: rst=1 at a rising edge clears the following.
  - snap = 0, div_cnt = 0, digit_idx = 0, frame_done = 0.
- Output values during and after reset: an = all ones, nibble = 0, dp = 1.
- Reset mid-scan: rst wins over load and over counter advance in the same cycle.
- Snapshot:
  - On load=1 (and rst=0), snap <= value.
  - The new value is visible on nibble the next cycle, mid-slot included.
  - With load=0, value changes are ignored.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1.
  - On div_cnt == REFRESH_DIV-1, div_cnt <= 0 and digit_idx <= digit_idx+1, wrapping NUM_DIGITS-1 -> 0.
- frame_done: registered; asserted for exactly the one cycle after the wrap of digit_idx from NUM_DIGITS-1 to 0.
- Output derivation: outputs depend only on registered state, with no combinational path from value, load or blank_lz to outputs.
  - nibble = snap[4*digit_idx +: 4].
  - Guard window: an = all ones when div_cnt < GUARD_CYCLES.
  - Outside the guard window: an[digit_idx] = 0 unless the digit is blanked; all other bits are 1.
  - dp = ~dp_mask[digit_idx] when an is active, else 1. dp_mask is sampled live and is not snapshotted.
- Leading-zero blanking:
  - Digit d is blanked when blank_lz=1, d != 0, and snap nibbles d..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so snap = 0 displays a single "0".
  - blank_lz is sampled live.
  - A blanked digit keeps its full slot time; scan timing never depends on value.
- Widths: digit_idx width = clog2(NUM_DIGITS), minimum 1. div_cnt width = clog2(REFRESH_DIV). No truncation warnings allowed.

Test Plan:
Bench configuration for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
- Reset: hold rst 3 cycles with load=1, value=16'hFFFF -> an=4'b1111, nibble=0, dp=1, digit_idx=0, frame_done=0. First cycle after release shows nibble=0 with an=1111 (guard).
- Scan order: load 16'h12AB, blank_lz=0. Per 4-cycle slot, an = 1111 for 1 cycle then the active pattern for 3 cycles:
  - digit 0: nibble=B, an=1110.
  - digit 1: nibble=A, an=1101.
  - digit 2: nibble=2, an=1011.
  - digit 3: nibble=1, an=0111.
  - frame_done pulses once every 16 cycles, the cycle after digit_idx 3->0.
- Leading-zero blanking, non-zero value: load 16'h0005, blank_lz=1 -> digit 0 shows nibble=5 with an=1110; digits 1-3 keep an=1111 throughout their slots.
- Leading-zero blanking, zero and interior zeros: load 16'h0000 -> digit 0 shows nibble=0 lit. Load 16'h0105 -> digits 0, 1, 2 lit (interior zero shown); digit 3 blanked.
- Decimal point: dp_mask=4'b0100 -> dp=0 only during the 3 active cycles of digit 2; dp=1 in all guard cycles and other slots.
- Load and reset mid-scan:
  - Change value without load during digit 1 -> nibble unchanged.
  - Pulse load with 16'h00C0 -> nibble=C the next cycle.
  - Assert rst at digit 2, div_cnt=2 -> next cycle shows all reset values and snap=0; scan restarts at digit 0.
